muldiv_hilo_ctrl: RTL and testbench

- Sequencer for MIPS-style multiply/divide that owns the architectural HI/LO registers.
- Multiplies are issued to the shared ALU's 64-bit multiply ops (4'b0110 signed, 4'b0111 unsigned) over a request/grant handshake.
- Divides run iteratively inside the block (restoring, 1 bit/cycle).
- Sits beside the ALU in the execute stage; the pipeline stalls on req_ready low and reads hi/lo directly.

---
 rtl/muldiv_hilo_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for MIPS mult/div: multiplies go to the shared ALU, divides run here (restoring, 1 bit/cycle).
// Optional macro MULDIV_DIV0_FLAG_EN adds a div0 output that pulses with done on divide-by-zero.
module muldiv_hilo_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic        div0
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_t      state;
  logic        alive;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_signed;
  logic        div_signed;
  logic        div_zero;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;

  logic        accept;
  logic        op_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // alive keeps req_ready low until the first edge after reset is released
  assign req_ready = alive && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign alu_req   = (state == S_MUL);
  assign alu_op    = alu_req ? (mul_signed ? 4'b0110 : 4'b0111) : 4'b0000;
  assign alu_a     = alu_req ? op_a : 32'h0;
  assign alu_b     = alu_req ? op_b : 32'h0;

  assign accept    = req_valid && req_ready;
  assign op_signed = ~req_op[0];
  assign a_mag     = (op_signed && req_a[31]) ? -req_a : req_a;
  assign b_mag     = (op_signed && req_b[31]) ? -req_b : req_b;

  // One restoring step: shift next dividend bit into rem, keep the subtraction if it did not borrow
  assign rem_sh    = {rem, quo[31]};
  assign trial     = rem_sh - {1'b0, dvs};

  assign quo_fix   = (div_signed && (op_a[31] ^ op_b[31])) ? -quo : quo;
  assign rem_fix   = (div_signed && op_a[31]) ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      alive      <= 1'b0;
      done       <= 1'b0;
      hi         <= 32'h0;
      lo         <= 32'h0;
      op_a       <= 32'h0;
      op_b       <= 32'h0;
      mul_signed <= 1'b0;
      div_signed <= 1'b0;
      div_zero   <= 1'b0;
      rem        <= 32'h0;
      quo        <= 32'h0;
      dvs        <= 32'h0;
      cnt        <= 6'h0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0       <= 1'b0;
`endif
    end else begin
      alive <= 1'b1;
      done  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a <= req_a;
            op_b <= req_b;
            cnt  <= 6'h0;
            case (req_op)
              3'b000, 3'b001: begin
                mul_signed <= op_signed;
                state      <= S_MUL;
              end
              3'b010, 3'b011: begin
                div_signed <= op_signed;
                rem        <= 32'h0;
                quo        <= a_mag;
                dvs        <= b_mag;
                div_zero   <= (req_b == 32'h0);
                state      <= (req_b == 32'h0) ? S_FIX : S_DIV;
              end
              3'b100: begin
                hi   <= req_a;
                done <= 1'b1;
              end
              3'b101: begin
                lo   <= req_a;
                done <= 1'b1;
              end
              default: done <= 1'b1;
            endcase
          end
        end

        S_MUL: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (alu_gnt) begin
            if (cnt == MUL_LAST) begin
              hi    <= alu_hi;
              lo    <= alu_lo;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end

        S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            if (!trial[32]) begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= rem_sh[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
            if (cnt == DIV_LAST) state <= S_FIX;
          end
        end

        S_FIX: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            if (div_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= op_a;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
            done  <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
            div0  <= div_zero;
`endif
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed and $urandom stimulus checked against plain-arithmetic mult/div reference.
module tb_muldiv_hilo_ctrl;
  localparam int LAT = 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_gnt = 1'b1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div0;
`endif

  int checks = 0;
  int errors = 0;

  muldiv_hilo_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_hi(alu_hi), .alu_lo(alu_lo)
`ifdef MULDIV_DIV0_FLAG_EN
    , .div0(div0)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Shared ALU stand-in: product of whatever the block presents
  assign {alu_hi, alu_lo} = (alu_op == 4'b0110) ? prod(1'b1, alu_a, alu_b) :
                            (alu_op == 4'b0111) ? prod(1'b0, alu_a, alu_b) : 64'h0;

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint qq;
    longint rr;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL issue_ready_timeout req_ready=%b expected 1", req_ready);
    end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (alu_req !== 1'b0) begin errors++; $display("FAIL reset_alu_req got %b expected 0", alu_req); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h_%h expected 0", hi, lo); end
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b expected 1", req_ready); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_no_accept hi got %h expected 0", hi); end
  endtask

  task automatic test_mult_directed;
    int n;
    alu_gnt = 1'b1;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    checks++; if (alu_req !== 1'b1 || alu_op !== 4'b0110) begin errors++; $display("FAIL mult_alu_req req=%b op=%b expected 1/0110", alu_req, alu_op); end
    checks++; if (alu_a !== 32'hFFFF_FFFD || alu_b !== 32'd7) begin errors++; $display("FAIL mult_operands a=%h b=%h expected fffffffd/7", alu_a, alu_b); end
    wait_done(20, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL mult_latency got %0d edges expected 1", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_result got %h_%h expected ffffffff_ffffffeb", hi, lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || alu_req !== 1'b0 || alu_op !== 4'b0) begin errors++; $display("FAIL mult_after done=%b alu_req=%b op=%b expected 0/0/0", done, alu_req, alu_op); end
  endtask

  task automatic test_multu_stall;
    alu_gnt = 1'b0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alu_req !== 1'b1 || req_ready !== 1'b0 || alu_op !== 4'b0111 || done !== 1'b0) begin
        errors++; $display("FAIL multu_stall cycle %0d req=%b ready=%b op=%b done=%b expected 1/0/0111/0", i, alu_req, req_ready, alu_op, done);
      end
      @(posedge clk); #1;
    end
    alu_gnt = 1'b1;
    checks++; if (alu_req !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL multu_grant_cycle req=%b ready=%b expected 1/0", alu_req, req_ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done got %b expected 1", done); end
    checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result got %h_%h expected 00000001_fffffffe", hi, lo); end
    checks++; if (alu_req !== 1'b0) begin errors++; $display("FAIL multu_req_drop got %b expected 0", alu_req); end
  endtask

  task automatic test_mul_random;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          g;
    int          n;
    for (int it = 0; it < 8; it++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      exp = prod(sgn, a, b);
      alu_gnt = 1'b0;
      issue(sgn ? OP_MULT : OP_MULTU, a, b);
      g = 0; n = 0;
      while (done !== 1'b1 && n < 60) begin
        alu_gnt = 1'($urandom_range(0, 1));
        if (alu_gnt) g++;
        @(posedge clk); #1;
        n++;
      end
      checks++; if (done !== 1'b1 || g !== LAT) begin errors++; $display("FAIL mul_rand_grants it %0d done=%b grants=%0d expected 1/%0d", it, done, g, LAT); end
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL mul_rand_result it %0d got %h_%h expected %h", it, hi, lo, exp); end
    end
    alu_gnt = 1'b1;
  endtask

  task automatic test_div_directed;
    logic [2:0]  t_op[4] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    logic [31:0] t_a[4]  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
    logic [31:0] t_b[4]  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_lo[4] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] t_hi[4] = '{32'hFFFF_FFFF, 32'd2, 32'h0, 32'd5};
    int          t_n[4]  = '{33, 33, 33, 1};
    int          n;
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL div_dir_busy case %0d busy=%b ready=%b expected 1/0", i, busy, req_ready); end
      wait_done(40, n);
      checks++; if (n !== t_n[i]) begin errors++; $display("FAIL div_dir_latency case %0d got %0d edges expected %0d", i, n, t_n[i]); end
      checks++; if (lo !== t_lo[i] || hi !== t_hi[i]) begin errors++; $display("FAIL div_dir_result case %0d got hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]); end
`ifdef MULDIV_DIV0_FLAG_EN
      checks++; if (div0 !== (t_b[i] == 32'h0)) begin errors++; $display("FAIL div_dir_div0 case %0d got %b expected %b", i, div0, (t_b[i] == 32'h0)); end
`endif
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_dir_pulse case %0d done=%b expected 0", i, done); end
    end
  endtask

  task automatic test_div_random;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        sgn;
    int          n;
    for (int it = 0; it < 10; it++) begin
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_div(sgn, a, b, eq, er);
      issue(sgn ? OP_DIV : OP_DIVU, a, b);
      wait_done(40, n);
      checks++; if (n !== ((b == 32'h0) ? 1 : 33)) begin errors++; $display("FAIL div_rand_latency it %0d got %0d edges", it, n); end
      checks++; if (lo !== eq || hi !== er) begin errors++; $display("FAIL div_rand_result it %0d a=%h b=%h s=%b got hi=%h lo=%h expected hi=%h lo=%h", it, a, b, sgn, hi, lo, er, eq); end
    end
  endtask

  task automatic test_mthi_mtlo;
    int n;
    req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h1234; req_b = 32'h0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || hi !== 32'h1234) begin errors++; $display("FAIL mthi done=%b hi=%h expected 1/00001234", done, hi); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mthi_ready got %b expected 1", req_ready); end
    req_op = OP_MTLO; req_a = 32'h5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (done !== 1'b1 || lo !== 32'h5678 || hi !== 32'h1234) begin errors++; $display("FAIL mtlo done=%b hi=%h lo=%h expected 1/1234/5678", done, hi, lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_pulse done=%b expected 0", done); end
    issue(OP_NOP, 32'hFFFF_0000, 32'h1);
    wait_done(5, n);
    checks++; if (n !== 0 || hi !== 32'h1234 || lo !== 32'h5678) begin errors++; $display("FAIL nop n=%0d hi=%h lo=%h expected 0/1234/5678", n, hi, lo); end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_done(40, n);
    checks++; if (req_ready !== 1'b1 || lo !== 32'd333 || hi !== 32'd1) begin errors++; $display("FAIL b2b_first ready=%b hi=%h lo=%h expected 1/1/14d", req_ready, hi, lo); end
    issue(OP_MTLO, 32'hCAFE, 32'h0);
    checks++; if (done !== 1'b1 || lo !== 32'hCAFE || hi !== 32'd1) begin errors++; $display("FAIL b2b_second done=%b hi=%h lo=%h expected 1/1/cafe", done, hi, lo); end
  endtask

  task automatic test_cancel;
    logic seen;
    issue(OP_MTHI, 32'hAAAA, 32'h0);
    issue(OP_MTLO, 32'hBBBB, 32'h0);
    issue(OP_DIV, $urandom, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cancel_div busy=%b ready=%b done=%b expected 0/1/0", busy, req_ready, done); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || hi !== 32'hAAAA || lo !== 32'hBBBB) begin errors++; $display("FAIL cancel_div_hold seen_done=%b hi=%h lo=%h expected 0/aaaa/bbbb", seen, hi, lo); end

    alu_gnt = 1'b0;
    issue(OP_MULT, 32'h5, 32'h6);
    @(posedge clk); #1;
    cancel = 1'b1; alu_gnt = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (alu_req !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA || lo !== 32'hBBBB) begin errors++; $display("FAIL cancel_mul req=%b done=%b hi=%h lo=%h expected 0/0/aaaa/bbbb", alu_req, done, hi, lo); end

    issue(OP_DIVU, 32'd9, 32'd0);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (done !== 1'b0 || hi !== 32'hAAAA || lo !== 32'hBBBB || busy !== 1'b0) begin errors++; $display("FAIL cancel_fix done=%b hi=%h lo=%h busy=%b expected 0/aaaa/bbbb/0", done, hi, lo, busy); end

    cancel = 1'b1;
    issue(OP_MTHI, 32'h77, 32'h0);
    cancel = 1'b0;
    checks++; if (done !== 1'b1 || hi !== 32'h77) begin errors++; $display("FAIL cancel_idle done=%b hi=%h expected 1/77", done, hi); end
  endtask

  task automatic test_reset_mid_mul;
    issue(OP_MTHI, 32'h1111, 32'h0);
    issue(OP_MTLO, 32'h2222, 32'h0);
    alu_gnt = 1'b0;
    issue(OP_MULT, 32'h3, 32'h4);
    checks++; if (alu_req !== 1'b1) begin errors++; $display("FAIL rst_mul_pre alu_req=%b expected 1", alu_req); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (alu_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mul_ctrl req=%b busy=%b done=%b expected 0/0/0", alu_req, busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || req_ready !== 1'b0) begin errors++; $display("FAIL rst_mul_regs hi=%h lo=%h ready=%b expected 0/0/0", hi, lo, req_ready); end
    @(posedge clk); #1;
    reset = 1'b0; alu_gnt = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mul_release ready=%b busy=%b expected 1/0", req_ready, busy); end
  endtask

  initial begin
    test_reset;
    test_mult_directed;
    test_multu_stall;
    test_mul_random;
    test_div_directed;
    test_div_random;
    test_mthi_mtlo;
    test_back_to_back;
    test_cancel;
    test_reset_mid_mul;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
